rv16_serial_add_unit: RTL and testbench
=======================================

# rv16_serial_add_unit

Bit-serial, multi-cycle adder for the rv16 datapath. It is the additive counterpart of the combinational subtract unit. It accepts two DATA-bit operands and a carry-in through a valid/ready handshake. It then ripples one bit per clock, LSB first, through a single full-adder cell and a registered carry, and presents the sum with carry, signed-overflow and zero flags through a second valid/ready handshake. It sits beside the subtract unit in the ALU, and the ALU sequencer stalls on it.

## Interface
- DATA, 16, operand/result width in bits; legal range DATA ≥ 2.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- rs1_add_in  input  DATA  operand A; sampled only on the accept edge.
- rs2_add_in  input  DATA  operand B; sampled only on the accept edge.
- cin  input  1  carry-in; sampled only on the accept edge.
- add_valid_in  input  1  request; an operation is accepted when add_valid_in=1 and add_ready_out=1 at a rising edge.
- add_ready_out  output  1  high only in IDLE.
- rd_add_out  output  DATA  registered sum A+B+cin, modulo 2^DATA.
- cout  output  1  registered carry out of bit DATA-1.
- ovf_out  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- zero_out  output  1  registered, 1 when rd_add_out == 0.
- add_valid_out  output  1  high only in DONE.
- add_ready_in  input  1  consumer accepts the result when add_valid_out=1 and add_ready_in=1 at a rising edge.

## Operation
- **State:** FSM with states IDLE, RUN and DONE.
- **Internal registers:**
  - shift registers a_sh and b_sh (DATA bits each)
  - result shift register s_sh (DATA bits)
  - carry register c
  - previous-carry register c_prev, which captures the carry into the current bit
  - bit counter cnt, width $clog2(DATA)
- **IDLE:**
  - add_ready_out=1.
  - On accept: a_sh←rs1_add_in, b_sh←rs2_add_in, c←cin, cnt←0, go to RUN.
  - When add_valid_in=0, the FSM stays in IDLE and the inputs are ignored.
- **RUN, one bit per cycle:**
  - sum bit = a_sh[0]^b_sh[0]^c.
  - s_sh ← {sum bit, s_sh[DATA-1:1]}.
  - c ← majority(a_sh[0], b_sh[0], c).
  - c_prev ← c.
  - a_sh and b_sh shift right by 1.
  - cnt increments.
  - When cnt==DATA-1, this cycle processes the MSB and the FSM goes to DONE.
  - Operand, cin and add_valid_in changes during RUN are ignored.
- **Transition into DONE:**
  - rd_add_out ← final sum vector.
  - cout ← final carry.
  - ovf_out ← c_prev_final ^ cout, where c_prev_final is the carry into bit DATA-1.
  - zero_out ← (final sum == 0).
- **DONE:**
  - add_valid_out=1 and add_ready_out=0.
  - Outputs are held stable for as long as add_ready_in=0 (backpressure).
  - On add_ready_in=1 the FSM goes to IDLE.
- **Output hold:** result outputs keep their last value after leaving DONE, until the next DONE entry overwrites them.
- **Arithmetic:** unsigned modulo 2^DATA. cout and ovf_out are independent, so both may be 1 together.

## Timing
- **Reset:** rst_n=0 at any rising edge, including mid-RUN or in DONE, has this effect:
  - FSM goes to IDLE; any in-flight operation is discarded with no output.
  - rd_add_out, cout, ovf_out, zero_out, s_sh, c, c_prev and cnt are all cleared to 0.
  - After the reset edge: add_ready_out=1 and add_valid_out=0.
  - Reset has priority over every handshake.
- **Latency:** accept at edge E0 gives add_valid_out=1 and valid results immediately after edge E0+DATA (16 cycles for DATA=16).
- **Throughput:** at most one operation per DATA+2 cycles: DATA cycles in RUN, ≥1 in DONE, 1 in IDLE. No accept is possible in DONE.
- **Handshake registration:** add_ready_out and add_valid_out are decoded from registered state only. There is no combinational path from any input to any output.
- **Simultaneous events:** when add_valid_in=1 arrives while in RUN or DONE, it is not accepted. The requester must hold it until add_ready_out=1.

## Test plan
- **Basic add:** reset, then accept 0x1234 + 0x1111 with cin=0 → exactly 16 cycles later add_valid_out=1, with rd_add_out=0x2345, cout=0, ovf_out=0, zero_out=0; add_ready_out=0 throughout.
- **Carry and zero:** 0xFFFF + 0x0001 with cin=0 → rd_add_out=0x0000, cout=1, ovf_out=0, zero_out=1. Then 0x8000 + 0x8000 → 0x0000, cout=1, ovf_out=1, zero_out=1.
- **Signed overflow and carry-in:** 0x7FFF + 0x0001 with cin=0 → 0x8000, ovf_out=1, cout=0. Then 0x0000 + 0x0000 with cin=1 → 0x0001, all flags 0.
- **Backpressure:** hold add_ready_in=0 for 5 cycles after add_valid_out rises → outputs remain stable throughout. Drive add_valid_in=1 with new operands during RUN and DONE → not accepted. Raise add_ready_in → IDLE next cycle, add_ready_out=1.
- **Reset mid-operation:** assert rst_n=0 for one edge, 8 cycles into RUN → IDLE, all outputs 0, add_ready_out=1, no add_valid_out pulse. The next operation, 0x00FF + 0x0001, gives 0x0100 with correct 16-cycle latency.
- **Back-to-back:** stream 4 operations with add_ready_in tied to 1 → each completes DATA+2 cycles apart, and every result matches A+B+cin mod 2^16.

Source files
------------

// File: rtl/rv16_add_if.sv
// Handshake and data bundle between the rv16 ALU sequencer and the bit-serial add unit.
interface rv16_add_if #(
  parameter int DATA = 16
) ();
  logic [DATA-1:0] rs1_add_in;
  logic [DATA-1:0] rs2_add_in;
  logic            cin;
  logic            add_valid_in;
  logic            add_ready_out;
  logic [DATA-1:0] rd_add_out;
  logic            cout;
  logic            ovf_out;
  logic            zero_out;
  logic            add_valid_out;
  logic            add_ready_in;

  modport master (
    output rs1_add_in, rs2_add_in, cin, add_valid_in, add_ready_in,
    input  add_ready_out, rd_add_out, cout, ovf_out, zero_out, add_valid_out
  );

  modport slave (
    input  rs1_add_in, rs2_add_in, cin, add_valid_in, add_ready_in,
    output add_ready_out, rd_add_out, cout, ovf_out, zero_out, add_valid_out
  );
endinterface

// File: rtl/rv16_serial_add_unit.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first, DATA cycles per add.
// state | meaning
// IDLE  | ready for a new operand pair
// RUN   | rippling one bit per clock through the full-adder cell
// DONE  | result presented, waiting for the consumer to take it
module rv16_serial_add_unit #(
  parameter int DATA = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  rv16_add_if.slave bus
);
  localparam int CNT_W = (DATA > 1) ? $clog2(DATA) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DATA-1:0] a_sh;
  logic [DATA-1:0] b_sh;
  logic [DATA-1:0] s_sh;
  logic            c;
  logic            c_prev;
  logic [CNT_W-1:0] cnt;

  logic            sum_bit;
  logic            carry_nxt;
  logic            last_bit;
  logic            accept;
  logic [DATA-1:0] sum_vec;

  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ c;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last_bit  = (cnt == CNT_W'(DATA - 1));
  assign accept    = (state == IDLE) && bus.add_valid_in;
  assign sum_vec   = {sum_bit, s_sh[DATA-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.add_ready_out = 1'b0;
    bus.add_valid_out = 1'b0;
    case (state)
      IDLE: begin
        bus.add_ready_out = 1'b1;
        if (bus.add_valid_in) state_nxt = RUN;
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        bus.add_valid_out = 1'b1;
        if (bus.add_ready_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On the MSB cycle c is the carry into bit DATA-1, so c ^ carry_nxt is the signed overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh           <= '0;
      b_sh           <= '0;
      s_sh           <= '0;
      c              <= 1'b0;
      c_prev         <= 1'b0;
      cnt            <= '0;
      bus.rd_add_out <= '0;
      bus.cout       <= 1'b0;
      bus.ovf_out    <= 1'b0;
      bus.zero_out   <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.rs1_add_in;
      b_sh <= bus.rs2_add_in;
      c    <= bus.cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      s_sh   <= sum_vec;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      c      <= carry_nxt;
      c_prev <= c;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        bus.rd_add_out <= sum_vec;
        bus.cout       <= carry_nxt;
        bus.ovf_out    <= c ^ carry_nxt;
        bus.zero_out   <= (sum_vec == '0);
      end
    end
  end
endmodule

// File: tb/tb_rv16_serial_add_unit.sv
// Directed and randomized bench for the bit-serial adder against an arithmetic reference model.
module tb_rv16_serial_add_unit;
  localparam int DATA = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rv16_add_if #(.DATA(DATA)) bus ();

  rv16_serial_add_unit #(.DATA(DATA)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, signed overflow from operand/result signs.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       output logic [15:0] sum, output logic co, output logic ov,
                       output logic zr);
    logic [16:0] full;
    full = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    sum  = full[15:0];
    co   = full[16];
    ov   = (a[15] == b[15]) && (sum[15] != a[15]);
    zr   = (sum == 16'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input int hold, input bit junk);
    logic [15:0] es;
    logic        ec, eo, ez;
    int          lat;
    logic        rdy_seen;
    model(a, b, ci, es, ec, eo, ez);
    bus.rs1_add_in   = a;
    bus.rs2_add_in   = b;
    bus.cin          = ci;
    bus.add_valid_in = 1'b1;
    bus.add_ready_in = 1'b0;
    chk("ready_before_accept", {31'd0, bus.add_ready_out}, 32'd1);
    step();
    bus.add_valid_in = junk;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!bus.add_valid_out && lat < 40) begin
      rdy_seen = rdy_seen | bus.add_ready_out;
      if (junk) begin
        bus.rs1_add_in = 16'($urandom);
        bus.rs2_add_in = 16'($urandom);
        bus.cin        = 1'($urandom);
      end
      step();
      lat++;
    end
    chk("latency", lat, DATA);
    chk("ready_low_in_run", {31'd0, rdy_seen}, 32'd0);
    chk("sum", {16'd0, bus.rd_add_out}, {16'd0, es});
    chk("cout", {31'd0, bus.cout}, {31'd0, ec});
    chk("ovf", {31'd0, bus.ovf_out}, {31'd0, eo});
    chk("zero", {31'd0, bus.zero_out}, {31'd0, ez});
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        bus.rs1_add_in = 16'($urandom);
        bus.rs2_add_in = 16'($urandom);
      end
      step();
      chk("hold_valid", {31'd0, bus.add_valid_out}, 32'd1);
      chk("hold_ready", {31'd0, bus.add_ready_out}, 32'd0);
      chk("hold_sum", {16'd0, bus.rd_add_out}, {16'd0, es});
      chk("hold_flags", {29'd0, bus.cout, bus.ovf_out, bus.zero_out}, {29'd0, ec, eo, ez});
    end
    bus.add_valid_in = 1'b0;
    bus.add_ready_in = 1'b1;
    step();
    bus.add_ready_in = 1'b0;
    chk("release_ready", {31'd0, bus.add_ready_out}, 32'd1);
    chk("release_valid", {31'd0, bus.add_valid_out}, 32'd0);
    chk("release_sum_held", {16'd0, bus.rd_add_out}, {16'd0, es});
  endtask

  initial begin
    logic [15:0] qa[4];
    logic [15:0] qb[4];
    logic        qc[4];
    logic [15:0] es;
    logic        ec, eo, ez;
    int          idx, done_n, cyc, last;
    logic        acc, pulse;

    checks = 0;
    errors = 0;
    rst_n            = 1'b0;
    bus.rs1_add_in   = '0;
    bus.rs2_add_in   = '0;
    bus.cin          = 1'b0;
    bus.add_valid_in = 1'b0;
    bus.add_ready_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_ready", {31'd0, bus.add_ready_out}, 32'd1);
    chk("rst_valid", {31'd0, bus.add_valid_out}, 32'd0);
    chk("rst_sum", {16'd0, bus.rd_add_out}, 32'd0);
    chk("rst_flags", {29'd0, bus.cout, bus.ovf_out, bus.zero_out}, 32'd0);

    run_op(16'h1234, 16'h1111, 1'b0, 0, 1'b0);
    chk("basic_const", {16'd0, bus.rd_add_out}, 32'h2345);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    chk("carry_zero_flags", {29'd0, bus.cout, bus.ovf_out, bus.zero_out}, 32'b101);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    chk("both_flags", {29'd0, bus.cout, bus.ovf_out, bus.zero_out}, 32'b111);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    chk("pos_ovf", {16'd0, bus.rd_add_out}, 32'h8000);
    run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
    chk("cin_only", {16'd0, bus.rd_add_out}, 32'h0001);

    run_op(16'hA5A5, 16'h5A5B, 1'b1, 5, 1'b1);

    for (int i = 0; i < 6; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

    run_op(16'h4321, 16'h0101, 1'b0, 0, 1'b0);
    bus.rs1_add_in   = 16'hFFFF;
    bus.rs2_add_in   = 16'hFFFF;
    bus.cin          = 1'b1;
    bus.add_valid_in = 1'b1;
    step();
    bus.add_valid_in = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_ready", {31'd0, bus.add_ready_out}, 32'd1);
    chk("midrst_valid", {31'd0, bus.add_valid_out}, 32'd0);
    chk("midrst_sum", {16'd0, bus.rd_add_out}, 32'd0);
    chk("midrst_flags", {29'd0, bus.cout, bus.ovf_out, bus.zero_out}, 32'd0);
    pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulse = pulse | bus.add_valid_out;
    end
    chk("midrst_no_pulse", {31'd0, pulse}, 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    chk("after_rst_sum", {16'd0, bus.rd_add_out}, 32'h0100);

    for (int i = 0; i < 4; i++) begin
      qa[i] = 16'($urandom);
      qb[i] = 16'($urandom);
      qc[i] = 1'($urandom);
    end
    bus.add_ready_in = 1'b1;
    idx              = 0;
    bus.rs1_add_in   = qa[0];
    bus.rs2_add_in   = qb[0];
    bus.cin          = qc[0];
    bus.add_valid_in = 1'b1;
    done_n = 0;
    cyc    = 0;
    last   = -1;
    while (done_n < 4 && cyc < 200) begin
      acc = bus.add_ready_out && bus.add_valid_in;
      if (bus.add_valid_out) begin
        model(qa[done_n], qb[done_n], qc[done_n], es, ec, eo, ez);
        chk("b2b_sum", {16'd0, bus.rd_add_out}, {16'd0, es});
        chk("b2b_flags", {29'd0, bus.cout, bus.ovf_out, bus.zero_out}, {29'd0, ec, eo, ez});
        if (last >= 0) chk("b2b_spacing", cyc - last, DATA + 2);
        last = cyc;
        done_n++;
      end
      step();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          bus.rs1_add_in = qa[idx];
          bus.rs2_add_in = qb[idx];
          bus.cin        = qc[idx];
        end else begin
          bus.add_valid_in = 1'b0;
        end
      end
    end
    chk("b2b_count", done_n, 4);
    bus.add_ready_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
